dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the core's single-port data memory between two requesters.
//  Port 0 is the core load/store unit; port 1 is the loader/debug master that
//  preloads or inspects dmem images.
//  Sits between those masters and the dmem RAM, which has 1-cycle read latency.
//  Sequences grants, tracks the in-flight read owner, and guards port 1 against starvation.
// PARAMETERS
//  ADDRW     14  word-address width of dmem
//  DATAW     32  data width; byte strobe width is DATAW/8
//  MAX_WAIT  8   cycles port 1 may be denied before it is forced a grant (fixed-priority mode)
// PORTS
//  clk         in   1         clock; all state updates on posedge
//  rst         in   1         reset, asynchronous, active-high
//  p0_req      in   1         core request; addr/we/wdata/wstrb held stable until p0_gnt
//  p0_we       in   1         1 = write, 0 = read
//  p0_addr     in   ADDRW     word address
//  p0_wdata    in   DATAW     write data
//  p0_wstrb    in   DATAW/8   byte write enables
//  p0_gnt      out  1         request accepted this cycle (combinational)
//  p0_rvalid   out  1         read data valid (1 cycle after read grant)
//  p0_rdata    out  DATAW     read data
//  p1_*        same set as p0_* for the loader/debug port
//  mem_en      out  1         RAM access strobe
//  mem_we      out  1         RAM write enable
//  mem_addr    out  ADDRW     RAM address
//  mem_wdata   out  DATAW     RAM write data
//  mem_wstrb   out  DATAW/8   RAM byte strobes
//  mem_rdata   in   DATAW     RAM read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset (async, rst=1): p0/p1_gnt=0, p0/p1_rvalid=0, rdata=0, mem_en=0,
//    mem_we=0, mem_addr/wdata/wstrb=0, wait_cnt=0, last_gnt=1, rd_owner cleared.
//  - At most one grant per cycle.
//    Grant is combinational from req and registered state.
//    mem_* mirror the granted port's fields in the same cycle.
//    With no grant: mem_en=0, mem_we=0.
//  - Fixed-priority selection (default):
//    - p0 wins when both request.
//    - wait_cnt increments each cycle p1_req=1 & !p1_gnt; clears on p1_gnt or !p1_req.
//    - When wait_cnt==MAX_WAIT, p1 is granted over p0 for that one cycle.
//  - Read return:
//    - Read grant registers rd_owner={valid,port}.
//    - Next cycle: owner's rvalid=1, rdata=mem_rdata; other port's rvalid=0, rdata holds last value.
//    - Back-to-back reads from either port are allowed every cycle; no bubbles.
//  - Writes: granted in 1 cycle, no response strobe.
//  - A requester that drops req before gnt simply withdraws; no state is kept.
//  - Reset mid-read: pending rvalid is suppressed; no data is returned after reset deasserts.
//  - wait_cnt saturates at MAX_WAIT; no wrap-around.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined:
//    - Round-robin arbitration: on contention, grant goes to the port not in last_gnt.
//    - last_gnt updates on every grant.
//    - wait_cnt and MAX_WAIT are unused; wait_cnt is held at 0.
//  DMEM_ARB_RR_EN undefined: fixed priority plus starvation guard, as above.
// TESTING
//  1. p0 read addr 0x010 alone, RAM[0x010]=0xDEADBEEF:
//     -> p0_gnt same cycle; p0_rvalid=1, p0_rdata=0xDEADBEEF next cycle; p1_rvalid=0.
//  2. p1 write addr 0x020 data 0x12345678 wstrb 4'b0011, then p1 read 0x020 (RAM previously 0):
//     -> read returns 0x00005678.
//  3. p0 and p1 request every cycle, fixed priority, MAX_WAIT=8:
//     -> p0 granted 8 cycles, p1 granted on 9th, pattern repeats.
//  4. Same stimulus with DMEM_ARB_RR_EN:
//     -> grants alternate p0,p1,p0,... starting with p0 after reset.
//  5. p0 read granted, rst asserted for 1 cycle before rvalid:
//     -> no rvalid on either port; all outputs at reset values while rst=1.
//  6. Back-to-back reads: p0 @0x001, p1 @0x002, p0 @0x003 in consecutive cycles:
//     -> rvalid on p0,p1,p0 in the three following cycles, each with correct data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory (1-cycle read latency).
// Default: fixed priority to port 0 with a starvation guard for port 1; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int ADDRW    = 14,
  parameter int DATAW    = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDRW-1:0]     p0_addr,
  input  logic [DATAW-1:0]     p0_wdata,
  input  logic [DATAW/8-1:0]   p0_wstrb,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [DATAW-1:0]     p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDRW-1:0]     p1_addr,
  input  logic [DATAW-1:0]     p1_wdata,
  input  logic [DATAW/8-1:0]   p1_wstrb,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DATAW-1:0]     p1_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDRW-1:0]     mem_addr,
  output logic [DATAW-1:0]     mem_wdata,
  output logic [DATAW/8-1:0]   mem_wstrb,
  input  logic [DATAW-1:0]     mem_rdata
);

  // Handshake: a master holds req and its fields stable until it sees gnt in the
  // same cycle; req+gnt at a posedge is one accepted transfer. Dropping req
  // before gnt withdraws the request. Reads return rvalid exactly one cycle later.

  logic             rd_owner_valid;
  logic             rd_owner_port;
  logic [DATAW-1:0] p0_rdata_q;
  logic [DATAW-1:0] p1_rdata_q;
  logic             p1_wins;

`ifdef DMEM_ARB_RR_EN
  logic last_gnt;

  // On contention the port that did not win last time goes next.
  always_comb p1_wins = (last_gnt == 1'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (p0_gnt) begin
      last_gnt <= 1'b0;
    end else if (p1_gnt) begin
      last_gnt <= 1'b1;
    end
  end
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;

  always_comb p1_wins = (wait_cnt == CW'(MAX_WAIT));

  // Counts consecutive denied cycles of port 1; saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (p1_req && !p1_gnt) begin
      if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // Grants are suppressed while reset is held so outputs sit at reset values.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p1_req && (!p0_req || p1_wins)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (p0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wstrb = p0_wstrb;
    end else if (p1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wstrb = p1_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_valid <= 1'b0;
      rd_owner_port  <= 1'b0;
      p0_rdata_q     <= '0;
      p1_rdata_q     <= '0;
    end else begin
      rd_owner_valid <= mem_en && !mem_we;
      rd_owner_port  <= p1_gnt;
      if (p0_rvalid) p0_rdata_q <= mem_rdata;
      if (p1_rvalid) p1_rdata_q <= mem_rdata;
    end
  end

  // Returning data passes straight through; the idle port keeps its last word.
  always_comb begin
    p0_rvalid = rd_owner_valid && !rd_owner_port;
    p1_rvalid = rd_owner_valid &&  rd_owner_port;
    p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
    p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 1-cycle-latency RAM model.
// Expected arbitration order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;
  localparam int ADDRW = 14;
  localparam int DATAW = 32;

  logic             clk;
  logic             rst;
  logic             p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [ADDRW-1:0] p0_addr;
  logic [DATAW-1:0] p0_wdata, p0_rdata;
  logic [3:0]       p0_wstrb;
  logic             p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [ADDRW-1:0] p1_addr;
  logic [DATAW-1:0] p1_wdata, p1_rdata;
  logic [3:0]       p1_wstrb;
  logic             mem_en, mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata, mem_rdata;
  logic [3:0]       mem_wstrb;

  int checks;
  int failures;
  logic [DATAW-1:0] ram [256];

  dmem_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATAW-1:0] init_word(input logic [7:0] a);
    case (a)
      8'h01:   init_word = 32'hA1A1_0001;
      8'h02:   init_word = 32'hB2B2_0002;
      8'h03:   init_word = 32'hC3C3_0003;
      8'h10:   init_word = 32'hDEAD_BEEF;
      default: init_word = 32'h0000_0000;
    endcase
  endfunction

  // RAM model: image reloads while rst is high, byte-strobed writes, 1-cycle reads.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
  endtask

  task automatic drive_p0(input logic we, input logic [ADDRW-1:0] a,
                          input logic [DATAW-1:0] d, input logic [3:0] s);
    p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_wstrb = s;
  endtask

  task automatic drive_p1(input logic we, input logic [ADDRW-1:0] a,
                          input logic [DATAW-1:0] d, input logic [3:0] s);
    p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_wstrb = s;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_p0(1'b1, 14'h155, 32'hFFFF_FFFF, 4'hF);
    drive_p1(1'b0, 14'h0AA, 32'h1234_5678, 4'hF);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_mem_en_we: got %b expected 00", {mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin failures++; $display("FAIL reset_mem_fields: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_wstrb); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); end
    checks++; if ({p0_rdata, p1_rdata} !== '0) begin failures++; $display("FAIL reset_rdata: got %h/%h expected 0", p0_rdata, p1_rdata); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_p0_read();
    @(negedge clk);
    drive_p0(1'b0, 14'h010, '0, '0);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL p0rd_gnt: got %b expected 10", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 14'h010}) begin failures++; $display("FAIL p0rd_mem: got en=%b we=%b addr=%h expected 1 0 010", mem_en, mem_we, mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL p0rd_data: got v=%b d=%h expected 1 deadbeef", p0_rvalid, p0_rdata); end
    checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL p0rd_p1_rvalid: got %b expected 0", p1_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL p0rd_hold: got v=%b d=%h expected 0 deadbeef", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_p1_write_read();
    @(negedge clk);
    drive_p1(1'b1, 14'h020, 32'h1234_5678, 4'b0011);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin failures++; $display("FAIL p1wr_gnt: got %b expected 01", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 14'h020, 32'h1234_5678, 4'b0011}) begin
      failures++; $display("FAIL p1wr_mem: got en=%b we=%b a=%h d=%h s=%b expected 1 1 020 12345678 0011", mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    drive_p1(1'b0, 14'h020, '0, '0);
    #1;
    checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL p1wr_no_resp: got %b expected 0", p1_rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0000_5678) begin failures++; $display("FAIL p1rd_data: got v=%b d=%h expected 1 00005678", p1_rvalid, p1_rdata); end
    checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL p1rd_p0_rvalid: got %b expected 0", p0_rvalid); end
  endtask

  task automatic test_arbitration();
    logic exp_p1;
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive_p0(1'b0, 14'h040, '0, '0);
      drive_p1(1'b0, 14'h041, '0, '0);
`ifdef DMEM_ARB_RR_EN
      exp_p1 = (i % 2) == 1;
`else
      exp_p1 = (i % 9) == 8;
`endif
      #1;
      checks++; if ({p0_gnt, p1_gnt} !== {~exp_p1, exp_p1}) begin failures++; $display("FAIL arb_cycle%0d: got %b expected %b", i, {p0_gnt, p1_gnt}, {~exp_p1, exp_p1}); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_withdraw();
    logic exp_p1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_p0(1'b0, 14'h040, '0, '0);
      drive_p1(1'b0, 14'h041, '0, '0);
    end
    @(negedge clk);
    p1_req = 1'b0;
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL withdraw_drop: got %b expected 10", {p0_gnt, p1_gnt}); end
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      drive_p1(1'b0, 14'h041, '0, '0);
`ifdef DMEM_ARB_RR_EN
      exp_p1 = (j % 2) == 0;
`else
      exp_p1 = (j == 8);
`endif
      #1;
      checks++; if ({p0_gnt, p1_gnt} !== {~exp_p1, exp_p1}) begin failures++; $display("FAIL withdraw_cycle%0d: got %b expected %b", j, {p0_gnt, p1_gnt}, {~exp_p1, exp_p1}); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    drive_p0(1'b0, 14'h010, '0, '0);
    #1;
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt: got %b expected 1", p0_gnt); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({p0_gnt, p1_gnt, mem_en, mem_we} !== 4'b0000) begin failures++; $display("FAIL midrst_async: got %b expected 0000", {p0_gnt, p1_gnt, mem_en, mem_we}); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00 || p0_rdata !== '0) begin failures++; $display("FAIL midrst_held: got v=%b d=%h expected 00 0", {p0_rvalid, p1_rvalid}, p0_rdata); end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin failures++; $display("FAIL midrst_after%0d: got %b expected 00", k, {p0_rvalid, p1_rvalid}); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_p0(1'b0, 14'h001, '0, '0);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL b2b_gnt0: got %b expected 10", {p0_gnt, p1_gnt}); end
    @(negedge clk);
    p0_req = 1'b0;
    drive_p1(1'b0, 14'h002, '0, '0);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin failures++; $display("FAIL b2b_gnt1: got %b expected 01", {p0_gnt, p1_gnt}); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hA1A1_0001) begin failures++; $display("FAIL b2b_ret0: got v=%b d=%h expected 10 a1a10001", {p0_rvalid, p1_rvalid}, p0_rdata); end
    @(negedge clk);
    p1_req = 1'b0;
    drive_p0(1'b0, 14'h003, '0, '0);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL b2b_gnt2: got %b expected 10", {p0_gnt, p1_gnt}); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b01 || p1_rdata !== 32'hB2B2_0002) begin failures++; $display("FAIL b2b_ret1: got v=%b d=%h expected 01 b2b20002", {p0_rvalid, p1_rvalid}, p1_rdata); end
    checks++; if (p0_rdata !== 32'hA1A1_0001) begin failures++; $display("FAIL b2b_hold0: got %h expected a1a10001", p0_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hC3C3_0003) begin failures++; $display("FAIL b2b_ret2: got v=%b d=%h expected 10 c3c30003", {p0_rvalid, p1_rvalid}, p0_rdata); end
    checks++; if (p1_rdata !== 32'hB2B2_0002) begin failures++; $display("FAIL b2b_hold1: got %h expected b2b20002", p1_rdata); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    mem_rdata = '0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_p0_read();
    test_p1_write_read();
    test_arbitration();
    test_withdraw();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
